// File: rtl/sample_window_buffer_if.sv
// Sample stream and window output bundle for sample_window_buffer.
// master = producer/consumer side, slave = the buffer itself.
interface sample_window_buffer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_ready;
  logic             flush;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic [WIDTH-1:0] out3;
  logic [WIDTH-1:0] out4;
  logic [WIDTH-1:0] out5;
  logic [WIDTH-1:0] out6;
  logic [WIDTH-1:0] out7;
  logic             frame_valid;
  logic             frame_ack;
  logic [7:0]       frame_count;

  modport master (
    output s_data, s_valid, flush, frame_ack,
    input  s_ready, out0, out1, out2, out3, out4, out5, out6, out7,
           frame_valid, frame_count
  );

  modport slave (
    input  s_data, s_valid, flush, frame_ack,
    output s_ready, out0, out1, out2, out3, out4, out5, out6, out7,
           frame_valid, frame_count
  );
endinterface

// File: rtl/sample_window_buffer.sv
// Collects a decimated sample stream into 8-sample windows and hands each
// completed window to a double-buffered parallel output with valid/ack.
module sample_window_buffer #(
  parameter int WIDTH = 8,
  parameter int DECIM = 1
) (
  input  logic                 CLK100MHZ,
  input  logic                 rst,
  sample_window_buffer_if.slave bus
);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  localparam logic [7:0] DEC_LAST = 8'(DECIM - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] fill_p0 [8];
  logic [WIDTH-1:0] win_p1  [8];
  logic [2:0]       wr_idx;
  logic [7:0]       dec_cnt;
  logic             vld_p1;
  logic [7:0]       frame_count_q;
  logic             accept;
  logic             keep;
  logic             reload;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    keep    = 1'b0;
    reload  = 1'b0;
    case (state_q)
      FILL: begin
        accept = bus.s_valid;
        keep   = accept && !bus.flush && (dec_cnt == 8'd0);
        if (keep && (wr_idx == 3'd7)) state_d = FULL;
      end
      FULL: begin
        // Output slot is free when empty or being acked this edge.
        reload = !vld_p1 || bus.frame_ack;
        if (reload) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  // Stage p0: fill buffer, write index and decimation phase
  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      wr_idx  <= 3'd0;
      dec_cnt <= 8'd0;
      for (int i = 0; i < 8; i++) fill_p0[i] <= '0;
    end else if ((state_q == FILL) && bus.flush) begin
      wr_idx  <= 3'd0;
      dec_cnt <= 8'd0;
    end else if (accept) begin
      dec_cnt <= (dec_cnt == DEC_LAST) ? 8'd0 : dec_cnt + 8'd1;
      if (keep) begin
        fill_p0[wr_idx] <= bus.s_data;
        wr_idx          <= wr_idx + 3'd1;
      end
    end
  end

  // Stage p1: presented window, its valid flag and the window counter
  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      vld_p1        <= 1'b0;
      frame_count_q <= 8'd0;
      for (int i = 0; i < 8; i++) win_p1[i] <= '0;
    end else if (reload) begin
      win_p1        <= fill_p0;
      vld_p1        <= 1'b1;
      frame_count_q <= frame_count_q + 8'd1;
    end else if (vld_p1 && bus.frame_ack) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.s_ready     = (state_q == FILL);
  assign bus.frame_valid = vld_p1;
  assign bus.frame_count = frame_count_q;
  assign bus.out0        = win_p1[0];
  assign bus.out1        = win_p1[1];
  assign bus.out2        = win_p1[2];
  assign bus.out3        = win_p1[3];
  assign bus.out4        = win_p1[4];
  assign bus.out5        = win_p1[5];
  assign bus.out6        = win_p1[6];
  assign bus.out7        = win_p1[7];

endmodule
